zion_basic_circuit_lib_neg_pipe_stage: RTL
==========================================

// Module: zion_basic_circuit_lib_neg_pipe_stage
// PURPOSE
//   Registered, flow-controlled conditional two's-complement negation stage with overflow detection.
//   Sits directly upstream of the combinational negation/absolute-value logic in datapaths.
//   - Resolves the most-negative-value overflow case (saturate or wrap).
//   - Decouples upstream and downstream timing through a valid/ready handshake and a 1-entry skid buffer.
//   - Counts overflow events for debug.
// PARAMETERS
//   WIDTH_IN   16  width of input data iDat (signed two's complement), >=2
//   WIDTH_OUT  16  width of output data oDat; must be >= WIDTH_IN (elaboration error otherwise)
//   SATURATE   1   1: overflow result saturates to max positive; 0: overflow result wraps (two's-complement)
//   CNT_WIDTH  8   width of overflow event counter oOvfCnt
// PORTS
//   clk      input   1          clock, all state on rising edge
//   rst      input   1          asynchronous, active-high reset
//   iVld     input   1          upstream data valid
//   oRdy     output  1          stage can accept upstream data
//   iDat     input   WIDTH_IN   signed input operand
//   iNeg     input   1          1: negate iDat; 0: pass iDat (sign-extended)
//   oVld     output  1          downstream data valid
//   iRdy     input   1          downstream accepts data
//   oDat     output  WIDTH_OUT  signed result
//   oOvf     output  1          result of this beat overflowed (qualified by oVld)
//   oOvfCnt  output  CNT_WIDTH  saturating count of accepted overflowed beats
// BEHAVIOUR
//   Reset (async, while rst=1):
//     oVld=0, oRdy=0, oDat=0, oOvf=0, oOvfCnt=0, skid empty.
//     oRdy rises on first clk edge after rst deasserts.
//   Handshake:
//     upstream beat transfers when iVld&oRdy at clk edge; downstream beat when oVld&iRdy.
//     oVld/oDat/oOvf hold stable while oVld&~iRdy.
//     oRdy is a register (= skid buffer empty); no combinational iRdy->oRdy path.
//   Arithmetic (computed at input, registered):
//     ext = sign-extend iDat to WIDTH_OUT.
//     iNeg=0 -> res=ext, ovf=0.
//     iNeg=1 -> res=~ext+1.
//       ovf=1 only when WIDTH_OUT==WIDTH_IN and iDat==2^(W-1) (most negative);
//       then res = SATURATE ? 2^(W-1)-1 : iDat.
//     WIDTH_OUT>WIDTH_IN never overflows.
//   States (main reg M, skid reg S):
//     EMPTY (M,S empty): accept -> FULL.
//     FULL (M valid):
//       accept & drain -> FULL (M <= new);
//       accept & ~drain -> SKID (S <= new, oRdy <= 0);
//       drain only -> EMPTY.
//     SKID (M,S valid, oRdy=0): drain -> FULL (M <= S, oRdy <= 1); else hold.
//   Latency 1 cycle input->oVld when downstream ready; throughput 1 beat/cycle sustained.
//   Order strictly preserved; no beat dropped or duplicated.
//   oOvfCnt:
//     +1 on each accepted upstream beat with ovf=1; saturates at 2^CNT_WIDTH-1, no wrap.
//     Cleared only by rst.
//   Reset mid-operation: M and S contents discarded immediately, oVld drops asynchronously.
// TESTING
//   1. W=16/16 SAT=1: iDat=0x0005,iNeg=1, iRdy=1 -> next cycle oVld=1,oDat=0xFFFB,oOvf=0.
//   2. W=16/16: iDat=0x8000,iNeg=1 -> SAT=1: oDat=0x7FFF,oOvf=1,oOvfCnt=1; SAT=0: oDat=0x8000,oOvf=1.
//   3. WIDTH_IN=8,WIDTH_OUT=9: iDat=0x80,iNeg=1 -> oDat=0x080,oOvf=0; iDat=0xFF,iNeg=0 -> oDat=0x1FF.
//   4. Stream 1,2,3 with iRdy=0 from beat 2 -> oRdy=0 after 2 accepted; iRdy=1 -> outputs 1,2,3 in order, oRdy=1.
//   5. 300 overflow beats, CNT_WIDTH=8 -> oOvfCnt stops at 255.
//   6. rst pulse while SKID state -> oVld=0 immediately, oOvfCnt=0; post-reset beat passes with 1-cycle latency.

Source files
------------

// File: rtl/zion_basic_circuit_lib_neg_pipe_stage.sv
// Registered, flow-controlled conditional two's-complement negation stage.
// A main register plus a 1-entry skid buffer decouple upstream and downstream timing; overflow events are counted.
module zion_basic_circuit_lib_neg_pipe_stage #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 16,
    parameter int SATURATE  = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [WIDTH_IN-1:0]  iDat,
    input  logic                 iNeg,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic [WIDTH_OUT-1:0] oDat,
    output logic                 oOvf,
    output logic [CNT_WIDTH-1:0] oOvfCnt
);

    if (WIDTH_IN < 2) begin : g_bad_width_in
        $error("WIDTH_IN must be >= 2");
    end
    if (WIDTH_OUT < WIDTH_IN) begin : g_bad_width_out
        $error("WIDTH_OUT must be >= WIDTH_IN");
    end

    localparam logic [WIDTH_IN-1:0]  MIN_IN  = {1'b1, {(WIDTH_IN-1){1'b0}}};
    localparam logic [WIDTH_OUT-1:0] MAX_OUT = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] ONE_OUT = WIDTH_OUT'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_EMPTY = 2'd1,
        ST_FULL  = 2'd2,
        ST_SKID  = 2'd3
    } state_t;

    // Returns {ovf, result}; only the most negative input at equal widths can overflow.
    function automatic logic [WIDTH_OUT:0] neg_op(input logic [WIDTH_IN-1:0] dat, input logic neg);
        logic [WIDTH_OUT-1:0] ext;
        logic [WIDTH_OUT-1:0] res;
        logic                 ovf;
        ext = WIDTH_OUT'($signed(dat));
        res = ext;
        ovf = 1'b0;
        if (neg) begin
            if ((WIDTH_OUT == WIDTH_IN) && (dat == MIN_IN)) begin
                ovf = 1'b1;
                res = (SATURATE != 0) ? MAX_OUT : ext;
            end else begin
                res = ~ext + ONE_OUT;
            end
        end else begin
            res = ext;
        end
        return {ovf, res};
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   vld_r;
    logic                   rdy_r;
    logic                   vld_nxt_s;
    logic                   rdy_nxt_s;
    logic [WIDTH_OUT-1:0]   m_dat_r;
    logic                   m_ovf_r;
    logic [WIDTH_OUT-1:0]   s_dat_r;
    logic                   s_ovf_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [WIDTH_OUT-1:0]   in_dat_s;
    logic                   in_ovf_s;
    logic                   accept_s;
    logic                   drain_s;
    logic                   load_m_new_s;
    logic                   load_m_skid_s;
    logic                   load_s_s;

    assign {in_ovf_s, in_dat_s} = neg_op(iDat, iNeg);
    assign accept_s = iVld & rdy_r;
    assign drain_s  = vld_r & iRdy;

    // Next-state and register-load decode for the main/skid buffer pair.
    always_comb begin
        state_nxt_s   = state_r;
        load_m_new_s  = 1'b0;
        load_m_skid_s = 1'b0;
        load_s_s      = 1'b0;
        case (state_r)
            ST_INIT: begin
                state_nxt_s = ST_EMPTY;
            end
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s  = ST_FULL;
                    load_m_new_s = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s && drain_s) begin
                    state_nxt_s  = ST_FULL;
                    load_m_new_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = ST_SKID;
                    load_s_s    = 1'b1;
                end else if (drain_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_SKID: begin
                if (drain_s) begin
                    state_nxt_s   = ST_FULL;
                    load_m_skid_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SKID;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // Handshake flags are registered copies of the next-state decode, so oRdy never sees iRdy combinationally.
    always_comb begin
        vld_nxt_s = (state_nxt_s == ST_FULL) || (state_nxt_s == ST_SKID);
        rdy_nxt_s = (state_nxt_s == ST_EMPTY) || (state_nxt_s == ST_FULL);
    end

    // State and handshake flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
            vld_r   <= 1'b0;
            rdy_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            vld_r   <= vld_nxt_s;
            rdy_r   <= rdy_nxt_s;
        end
    end

    // Main output register: takes the new beat or the parked skid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dat_r <= {WIDTH_OUT{1'b0}};
            m_ovf_r <= 1'b0;
        end else if (load_m_new_s) begin
            m_dat_r <= in_dat_s;
            m_ovf_r <= in_ovf_s;
        end else if (load_m_skid_s) begin
            m_dat_r <= s_dat_r;
            m_ovf_r <= s_ovf_r;
        end else begin
            m_dat_r <= m_dat_r;
            m_ovf_r <= m_ovf_r;
        end
    end

    // Skid register: parks a beat accepted while the main register is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_dat_r <= {WIDTH_OUT{1'b0}};
            s_ovf_r <= 1'b0;
        end else if (load_s_s) begin
            s_dat_r <= in_dat_s;
            s_ovf_r <= in_ovf_s;
        end else begin
            s_dat_r <= s_dat_r;
            s_ovf_r <= s_ovf_r;
        end
    end

    // Saturating overflow event counter, counted at upstream acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (accept_s && in_ovf_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign oVld    = vld_r;
    assign oRdy    = rdy_r;
    assign oDat    = m_dat_r;
    assign oOvf    = m_ovf_r;
    assign oOvfCnt = cnt_r;

endmodule
